// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned MDU_WIDTH = 16;
   localparam int unsigned MDU_ITER  = MDU_WIDTH;

   typedef enum logic [1:0] {
      MULU = 2'b00,
      MULS = 2'b01,
      DIVU = 2'b10,
      DIVS = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FIXUP = 2'b10
   } mdu_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic               mode,
   input  logic [2*WIDTH:0]   partial,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH:0]   partial_next,
   output logic               q_bit
);

   logic [WIDTH:0]   hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   assign hi = partial[2*WIDTH:WIDTH];
   assign lo = partial[WIDTH-1:0];

   always_comb begin
      sum          = '0;
      shifted      = '0;
      diff         = '0;
      q_bit        = 1'b0;
      partial_next = partial;
      if (mode) begin
         // Remainder stays below the divisor, so bit WIDTH of diff is a clean borrow.
         shifted      = {hi[WIDTH-1:0], lo[WIDTH-1]};
         diff         = shifted - {1'b0, operand};
         q_bit        = ~diff[WIDTH];
         partial_next = {(q_bit ? diff : shifted), lo[WIDTH-2:0], 1'b0};
      end else begin
         sum          = lo[0] ? (hi + {1'b0, operand}) : hi;
         partial_next = {1'b0, sum, lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 16-bit multiply/divide coprocessor with sign fixup and ALU-style flags.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_hazard,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             n,
   output logic             z,
   output logic             p,
   output logic             c
);

   localparam int unsigned CntW = $clog2(WIDTH);

   mdu_state_t       state_q, state_d;
   mdu_op_t          op_q, op_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [2*WIDTH:0] part_q, part_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             neg_q, neg_d, rneg_q, rneg_d;
   logic             dz_q, dz_d, ovf_q, ovf_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic             n_q, n_d, z_q, z_d, p_q, p_d, c_q, c_d;

   logic             in_div, in_sgn;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             is_div_q;
   logic [2*WIDTH:0] step_next;
   logic             step_q;

   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
   logic               fix_n, fix_z, fix_c;

   assign in_div   = op[1];
   assign in_sgn   = op[0];
   assign a_mag    = (in_sgn && in_a[WIDTH-1]) ? -in_a : in_a;
   assign b_mag    = (in_sgn && in_b[WIDTH-1]) ? -in_b : in_b;
   assign is_div_q = (op_q == DIVU) || (op_q == DIVS);

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .mode         (is_div_q),
      .partial      (part_q),
      .operand      (opnd_q),
      .partial_next (step_next),
      .q_bit        (step_q)
   );

   always_comb begin
      prod     = {part_q[2*WIDTH-1:WIDTH], part_q[WIDTH-1:0]};
      prod_fix = neg_q ? -prod : prod;
      quo      = neg_q ? -part_q[WIDTH-1:0] : part_q[WIDTH-1:0];
      if (dz_q) begin
         quo = '1;
      end
      // Remainder takes the dividend's sign; this also restores in_a on divide by zero.
      rem    = rneg_q ? -part_q[2*WIDTH-1:WIDTH] : part_q[2*WIDTH-1:WIDTH];
      fix_hi = is_div_q ? rem : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = is_div_q ? quo : prod_fix[WIDTH-1:0];
      fix_n  = is_div_q ? quo[WIDTH-1] : fix_hi[WIDTH-1];
      fix_z  = is_div_q ? (quo == '0) : (prod_fix == '0);
      unique case (op_q)
         MULU:    fix_c = (fix_hi != '0);
         MULS:    fix_c = (fix_hi != {WIDTH{fix_lo[WIDTH-1]}});
         default: fix_c = dz_q | ovf_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      part_d   = part_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = done_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      n_d      = n_q;
      z_d      = z_q;
      p_d      = p_q;
      c_d      = c_q;
      if (!data_hazard) begin
         done_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  op_d    = mdu_op_t'(op);
                  part_d  = {{(WIDTH+1){1'b0}}, (in_div ? a_mag : b_mag)};
                  opnd_d  = in_div ? b_mag : a_mag;
                  neg_d   = in_sgn & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                  rneg_d  = in_sgn & in_div & in_a[WIDTH-1];
                  dz_d    = in_div && (in_b == '0);
                  ovf_d   = (op == 2'(DIVS)) && (in_a == {1'b1, {(WIDTH-1){1'b0}}})
                            && (in_b == '1);
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = CALC;
               end
            end
            CALC: begin
               part_d = step_next | {{(2*WIDTH){1'b0}}, step_q};
               cnt_d  = cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH-1)) begin
                  state_d = FIXUP;
               end
            end
            FIXUP: begin
               res_hi_d = fix_hi;
               res_lo_d = fix_lo;
               n_d      = fix_n;
               z_d      = fix_z;
               p_d      = ~fix_n & ~fix_z;
               c_d      = fix_c;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= MULU;
         cnt_q    <= '0;
         part_q   <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         n_q      <= 1'b0;
         z_q      <= 1'b0;
         p_q      <= 1'b0;
         c_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         part_q   <= part_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         n_q      <= n_d;
         z_q      <= z_d;
         p_q      <= p_d;
         c_q      <= c_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign res_hi = res_hi_q;
   assign res_lo = res_lo_q;
   assign n      = n_q;
   assign z      = z_q;
   assign p      = p_q;
   assign c      = c_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: results, flags and done latency against a behavioural model.
module tb_muldiv_unit;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic [3:0]  flags;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        data_hazard = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        busy, done, n, z, p, c;
   logic [15:0] res_hi, res_lo;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sb[$];

   muldiv_unit #(
      .WIDTH (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_hazard (data_hazard),
      .start       (start),
      .op          (op),
      .in_a        (in_a),
      .in_b        (in_b),
      .busy        (busy),
      .done        (done),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .n           (n),
      .z           (z),
      .p           (p),
      .c           (c)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, want);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [31:0] r;
      logic [15:0] hi, lo;
      logic        nf, zf, cf;
      int          sa, sbv, q, m;
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      r   = '0;
      hi  = '0;
      lo  = '0;
      cf  = 1'b0;
      case (o)
         2'd0: begin
            r  = {16'h0, a} * {16'h0, b};
            hi = r[31:16];
            lo = r[15:0];
            cf = (hi != 16'h0);
         end
         2'd1: begin
            m  = sa * sbv;
            r  = m;
            hi = r[31:16];
            lo = r[15:0];
            cf = (hi != {16{lo[15]}});
         end
         default: begin
            if (b == 16'h0) begin
               lo = 16'hFFFF;
               hi = a;
               cf = 1'b1;
            end else if (o == 2'd3 && a == 16'h8000 && b == 16'hFFFF) begin
               lo = 16'h8000;
               hi = 16'h0;
               cf = 1'b1;
            end else if (o == 2'd2) begin
               lo = a / b;
               hi = a % b;
            end else begin
               q  = sa / sbv;
               m  = sa % sbv;
               lo = q[15:0];
               hi = m[15:0];
            end
         end
      endcase
      nf      = o[1] ? lo[15] : hi[15];
      zf      = o[1] ? (lo == 16'h0) : ({hi, lo} == 32'h0);
      e.name  = "";
      e.res   = {hi, lo};
      e.flags = {nf, zf, ~nf & ~zf, cf};
      e.cyc   = 0;
      return e;
   endfunction

   // Drives start for one edge and queues the expected result and done cycle.
   task automatic start_op(input string name, input logic [1:0] o, input logic [15:0] a,
                           input logic [15:0] b, input int stall);
      exp_t e;
      op    = o;
      in_a  = a;
      in_b  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      e      = model(o, a, b);
      e.name = name;
      e.cyc  = cyc + 17 + stall;
      sb.push_back(e);
      start = 1'b0;
      check_eq({name, ".busy"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_eq("drain", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && done && !data_hazard) begin
         if (sb.size() == 0) begin
            check_eq("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq({e.name, ".res"}, {res_hi, res_lo}, e.res);
            check_eq({e.name, ".flags"}, 32'({n, z, p, c}), 32'(e.flags));
            check_eq({e.name, ".lat"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("reset.res", {res_hi, res_lo}, 32'h0);
      check_eq("reset.ctl", 32'({busy, done, n, z, p, c}), 32'h0);

      start_op("mulu_ff", 2'd0, 16'hFFFF, 16'hFFFF, 0);
      wait_idle();
      check_eq("idle.busy", 32'(busy), 32'd0);
      start_op("muls_neg", 2'd1, 16'hFFFD, 16'h0005, 0);
      wait_idle();
      start_op("muls_zero", 2'd1, 16'h0000, 16'h1234, 0);
      wait_idle();
      start_op("divu", 2'd2, 16'd100, 16'd7, 0);
      wait_idle();
      start_op("divs_neg", 2'd3, 16'hFFF9, 16'h0002, 0);
      wait_idle();
      start_op("divu_dz", 2'd2, 16'h1234, 16'h0000, 0);
      wait_idle();
      start_op("divs_dz", 2'd3, 16'hFFF0, 16'h0000, 0);
      wait_idle();
      start_op("divs_ovf", 2'd3, 16'h8000, 16'hFFFF, 0);
      wait_idle();

      // Five-edge stall in the middle of CALC.
      start_op("stall_mulu", 2'd0, 16'd3, 16'd4, 5);
      repeat (5) @(negedge clk);
      data_hazard = 1'b1;
      repeat (5) @(negedge clk);
      data_hazard = 1'b0;
      k = 0;
      while (!done && k < 100) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_eq("b2b.done", 32'(done), 32'd1);
      start_op("b2b_muls", 2'd1, 16'h8000, 16'h8000, 0);
      wait_idle();

      // Reset mid-divide: outputs clear at once and the aborted op never completes.
      start_op("rst_divu", 2'd2, 16'h1234, 16'd3, 0);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst.res", {res_hi, res_lo}, 32'h0);
      check_eq("midrst.ctl", 32'({busy, done, n, z, p, c}), 32'h0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check_eq("midrst.idle", 32'({busy, done}), 32'h0);
      start_op("after_rst", 2'd3, 16'hFF9C, 16'd7, 0);
      wait_idle();

      for (int i = 0; i < 8; i++) begin
         start_op("rand", 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 0);
         wait_idle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 16-bit multiply/divide coprocessor in the NeonFox CPU execute stage, beside the single-cycle ALU.
- Takes operands from the register-read stage and computes a fixed-latency product, or a quotient and remainder.
- Returns a 32-bit result pair plus n/z/p/c condition codes using the same flag conventions as the ALU.
- Honours the pipeline `data_hazard` stall.

Parameters:
- WIDTH, 16, operand width; result is 2*WIDTH; latency is WIDTH+2 cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_hazard  in  1  pipeline stall; freezes all state when high.
- start  in  1  request; sampled only in IDLE with data_hazard low.
- op  in  2  operation: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- in_a  in  WIDTH  multiplicand or dividend.
- in_b  in  WIDTH  multiplier or divisor.
- busy  out  1  operation in progress.
- done  out  1  one-cycle result-valid pulse.
- res_hi  out  WIDTH  MUL: product[31:16]; DIV: remainder.
- res_lo  out  WIDTH  MUL: product[15:0]; DIV: quotient.
- n, z, p, c  out  1 each  condition codes.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, res_hi, res_lo, n, z, p, c all 0. Reset mid-operation aborts the operation; no done is produced.
- States and transitions:
  - IDLE -> CALC on start.
  - CALC -> FIXUP after WIDTH iterations.
  - FIXUP -> IDLE.
- Edge k (start sampled in IDLE):
  - Latch op.
  - Latch operand magnitudes; signed ops take abs values and record the result sign(s).
  - Clear the iteration counter and partial remainder/product.
  - busy<=1.
- Edges k+1..k+16 (CALC): one radix-2 step per edge.
  - MUL: shift-add.
  - DIV: restoring shift-subtract.
  - Counter increments 0..15; wraps to FIXUP on the edge where it reaches 15.
- Edge k+17 (FIXUP):
  - Apply sign correction.
  - Write res_hi/res_lo and flags.
  - done<=1, busy<=0, state IDLE.
- Latency: done is high in the 18th cycle after start is sampled; busy is high for cycles k+1..k+17.
- done is held high for exactly one unstalled cycle. Results and flags hold until the next FIXUP.
- Back-to-back: start may be sampled in the done cycle, since the state is IDLE.
- start is ignored while busy. op/in_a/in_b are don't-care except at the start edge.
- data_hazard high:
  - No register changes: state, counter, datapath, outputs and done all hold.
  - done therefore stretches across the stall.
  - start is ignored.
  - Latency extends by the stall length.
- Signed rules:
  - MULS: two's-complement product.
  - DIVS: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (in_b=0):
  - Runs full latency.
  - Quotient all ones; remainder = in_a.
  - c=1.
  - Applies to DIVU and DIVS.
- DIVS overflow (0x8000 / 0xFFFF): quotient 0x8000, remainder 0, c=1.
- Flags, written at FIXUP only:
  - n = MSB of result (MUL: res_hi[15]; DIV: quotient[15]).
  - z = result zero (MUL: all 32 bits; DIV: quotient).
  - p = ~n & ~z.
  - c, MULU: res_hi != 0.
  - c, MULS: res_hi != {16{res_lo[15]}}.
  - c, DIV: c=1 on divide by zero or DIVS overflow, else 0.

Decomposition:
- Package muldiv_pkg:
  - Enum mdu_op_t: MULU, MULS, DIVU, DIVS.
  - Enum mdu_state_t: IDLE, CALC, FIXUP.
  - Constant MDU_ITER = WIDTH.
- Sub-module muldiv_step: combinational single iteration.
  - Inputs: mode, partial, operand.
  - Outputs: next partial, quotient bit.
  - Instantiated once in CALC.

Test Plan:
- MULU 0xFFFF*0xFFFF -> done at cycle 18; res_hi=0xFFFE, res_lo=0x0001, n=1, z=0, p=0, c=1.
- MULS 0xFFFD(-3)*0x0005 -> res_hi=0xFFFF, res_lo=0xFFF1, n=1, c=0; then MULS 0*0x1234 -> z=1, p=0, n=0.
- DIVU 100/7 -> res_lo=0x000E, res_hi=0x0002, p=1, c=0. DIVS 0xFFF9(-7)/2 -> res_lo=0xFFFD, res_hi=0xFFFF, n=1.
- DIVU 0x1234/0 -> res_lo=0xFFFF, res_hi=0x1234, c=1. DIVS 0x8000/0xFFFF -> res_lo=0x8000, res_hi=0, c=1.
- MULU 3*4 with data_hazard high for 5 cycles starting at cycle 6 -> done at cycle 23, result 0x0000000C. Second start in the done cycle (stall low) is accepted; done 18 cycles later.
- rst_n low at cycle 9 of a DIVU -> all outputs 0 immediately, no done. New start after reset completes normally.
